// File: rtl/pkt_to_bus_master_pkg.sv
// Shared NIC defines for the packet-to-Wishbone ejection path:
// bus widths, head/body flit layout, FSM encodings and cmd decode.
package pkt_to_bus_master_pkg;

  localparam int BUS_ADDRESS_WIDTH = 32;
  localparam int BUS_DATA_WIDTH    = 32;
  localparam int BUS_SEL_WIDTH     = BUS_DATA_WIDTH / 8;
  localparam int ADR_SHIFT         = $clog2(BUS_SEL_WIDTH);

  localparam int MAX_BURST_LENGHT  = 8;
  localparam int MAX_PACKET_LENGHT = MAX_BURST_LENGHT + 1;
  localparam int FLIT_WIDTH        = 40;
  localparam int PKT_WIDTH         = MAX_PACKET_LENGHT * FLIT_WIDTH;

  localparam int HEAD_ADR_LSB  = 0;
  localparam int HEAD_CMD_BIT  = 32;
  localparam int HEAD_LEN_LSB  = 33;
  localparam int HEAD_LEN_W    = 5;
  localparam int HEAD_VNET_LSB = 38;
  localparam int HEAD_VNET_W   = 2;

  localparam int BODY_DAT_LSB = 0;
  localparam int BODY_SEL_LSB = 32;

  localparam logic CMD_READ = 1'b1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_BUS    = 2'd2;
  localparam logic [1:0] S_REPLY  = 2'd3;

  typedef struct packed {
    logic [BUS_ADDRESS_WIDTH-1:0] addr;
    logic                         cmd;
    logic [HEAD_LEN_W-1:0]        len;
  } head_t;

  function automatic logic read_request(input logic cmd);
    return cmd == CMD_READ;
  endfunction

endpackage

// File: rtl/pkt_to_bus_master_pkt_to_msg.sv
// Combinational flit field extraction: head fields and the
// body flit (data/sel) belonging to the current beat.
module pkt_to_msg
  import pkt_to_bus_master_pkg::*;
#(
  parameter int BW = 6
) (
  input  logic [PKT_WIDTH-1:0]      pkt,
  input  logic [BW-1:0]             beat,
  output head_t                     head,
  output logic [BUS_DATA_WIDTH-1:0] data,
  output logic [BUS_SEL_WIDTH-1:0]  sel
);

  logic [FLIT_WIDTH-1:0] h;
  logic [FLIT_WIDTH-1:0] body;
  logic                  unused;

  assign h = pkt[FLIT_WIDTH-1:0];

  assign head.addr = h[HEAD_ADR_LSB +: BUS_ADDRESS_WIDTH];
  assign head.cmd  = h[HEAD_CMD_BIT];
  assign head.len  = h[HEAD_LEN_LSB +: HEAD_LEN_W];

  // beat k is carried by flit k+1
  always_comb begin
    body = '0;
    for (int i = 1; i < MAX_PACKET_LENGHT; i++)
      if (beat == BW'(i - 1))
        body = pkt[i*FLIT_WIDTH +: FLIT_WIDTH];
  end

  assign data = body[BODY_DAT_LSB +: BUS_DATA_WIDTH];
  assign sel  = body[BODY_SEL_LSB +: BUS_SEL_WIDTH];

  assign unused = ^{h[HEAD_VNET_LSB +: HEAD_VNET_W],
                    body[FLIT_WIDTH-1:BODY_SEL_LSB+BUS_SEL_WIDTH]};

endmodule

// File: rtl/pkt_to_bus_master.sv
// Replays one ejected packet as a Wishbone-classic burst;
// read bursts return the captured data as a reply.
module pkt_to_bus_master
  import pkt_to_bus_master_pkg::*;
#(
  parameter int N_BITS_VNET_ID      = 2,
  parameter int N_BITS_BURST_LENGHT = 5,
  parameter int TIMEOUT_CYCLES      = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PKT_WIDTH-1:0]          pkt_i,
  input  logic [N_BITS_VNET_ID-1:0]     vnet_id_i,
  input  logic                          pkt_valid_i,
  output logic                          pkt_ready_o,
  output logic                          CYC_O,
  output logic                          STB_O,
  output logic                          WE_O,
  output logic [BUS_ADDRESS_WIDTH-1:0]  ADR_O,
  output logic [BUS_DATA_WIDTH-1:0]     DAT_O,
  output logic [BUS_SEL_WIDTH-1:0]      SEL_O,
  input  logic [BUS_DATA_WIDTH-1:0]     DAT_I,
  input  logic                          ACK_I,
  input  logic                          ERR_I,
  output logic [MAX_BURST_LENGHT*BUS_DATA_WIDTH-1:0] reply_data_o,
  output logic [N_BITS_BURST_LENGHT:0]  reply_len_o,
  output logic [N_BITS_VNET_ID-1:0]     reply_vnet_o,
  output logic                          reply_valid_o,
  input  logic                          reply_ready_i,
  output logic                          err_o
);

  localparam int BW = N_BITS_BURST_LENGHT + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = MAX_BURST_LENGHT * BUS_DATA_WIDTH;

  logic [1:0]                   state;
  logic [PKT_WIDTH-1:0]         pkt_q;
  logic [N_BITS_VNET_ID-1:0]    vnet_q;
  logic                         rd_q;
  logic [BUS_ADDRESS_WIDTH-1:0] base_q;
  logic [BW-1:0]                len_q;
  logic [BW-1:0]                beat;
  logic [TW-1:0]                tcnt;
  logic [RW-1:0]                rdata_q;
  logic                         err_q;

  head_t                        head;
  logic [BUS_DATA_WIDTH-1:0]    body_dat;
  logic [BUS_SEL_WIDTH-1:0]     body_sel;
  logic [BW-1:0]                len_dec;
  logic [BUS_ADDRESS_WIDTH-1:0] adr_off;
  logic                         bus;
  logic                         last;
  logic                         tout;

  pkt_to_msg #(.BW(BW)) u_msg (
    .pkt  (pkt_q),
    .beat (beat),
    .head (head),
    .data (body_dat),
    .sel  (body_sel)
  );

  always_comb begin
    len_dec = BW'(head.len);
    if (len_dec > BW'(MAX_BURST_LENGHT))
      len_dec = BW'(MAX_BURST_LENGHT);
  end

  assign bus     = state == S_BUS;
  assign last    = beat == len_q - 1'b1;
  assign tout    = tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign adr_off = BUS_ADDRESS_WIDTH'(beat) << ADR_SHIFT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pkt_q   <= '0;
      vnet_q  <= '0;
      rd_q    <= 1'b0;
      base_q  <= '0;
      len_q   <= '0;
      beat    <= '0;
      tcnt    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pkt_valid_i) begin
            pkt_q  <= pkt_i;
            vnet_q <= vnet_id_i;
            state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          base_q  <= head.addr;
          rd_q    <= read_request(head.cmd);
          len_q   <= len_dec;
          beat    <= '0;
          tcnt    <= '0;
          rdata_q <= '0;
          if (head.len == '0) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            state <= S_BUS;
          end
        end
        S_BUS: begin
          // ERR_I wins over a simultaneous ACK_I
          if (ERR_I || (!ACK_I && tout)) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else if (ACK_I) begin
            tcnt <= '0;
            beat <= beat + 1'b1;
            if (rd_q)
              for (int i = 0; i < MAX_BURST_LENGHT; i++)
                if (beat == BW'(i))
                  rdata_q[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= DAT_I;
            if (last)
              state <= rd_q ? S_REPLY : S_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_REPLY: begin
          if (reply_ready_i)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pkt_ready_o   = (state == S_IDLE) && !rst;
  assign CYC_O         = bus;
  assign STB_O         = bus;
  assign WE_O          = bus && !rd_q;
  assign ADR_O         = bus ? base_q + adr_off : '0;
  assign DAT_O         = (bus && !rd_q) ? body_dat : '0;
  assign SEL_O         = bus ? (rd_q ? '1 : body_sel) : '0;
  assign reply_valid_o = state == S_REPLY;
  assign reply_data_o  = rdata_q;
  assign reply_len_o   = len_q;
  assign reply_vnet_o  = vnet_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_pkt_to_bus_master.sv
// Randomized bench for pkt_to_bus_master: a per-transaction timeline
// model drives the slave and predicts every output cycle by cycle.
module tb_pkt_to_bus_master;
  import pkt_to_bus_master_pkg::*;

  localparam int FW  = FLIT_WIDTH;
  localparam int MB  = MAX_BURST_LENGHT;
  localparam int BDW = BUS_DATA_WIDTH;
  localparam int TO  = 255;

  logic clk = 1'b0;
  logic rst;
  logic [PKT_WIDTH-1:0] pkt_i;
  logic [1:0] vnet_id_i;
  logic pkt_valid_i, pkt_ready_o;
  logic CYC_O, STB_O, WE_O;
  logic [31:0] ADR_O, DAT_O, DAT_I;
  logic [3:0] SEL_O;
  logic ACK_I, ERR_I;
  logic [MB*BDW-1:0] reply_data_o;
  logic [5:0] reply_len_o;
  logic [1:0] reply_vnet_o;
  logic reply_valid_o, reply_ready_i, err_o;

  pkt_to_bus_master #(
    .N_BITS_VNET_ID(2),
    .N_BITS_BURST_LENGHT(5),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .pkt_i(pkt_i), .vnet_id_i(vnet_id_i),
    .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O),
    .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I),
    .reply_data_o(reply_data_o), .reply_len_o(reply_len_o),
    .reply_vnet_o(reply_vnet_o), .reply_valid_o(reply_valid_o),
    .reply_ready_i(reply_ready_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic cmp_en = 1'b0;
  logic e_ready, e_cyc, e_we, e_rv, e_err;
  logic err_pend = 1'b0;
  logic [31:0] e_adr, e_dat;
  logic [3:0] e_sel;
  logic [5:0] e_len;
  logic [1:0] e_vnet;
  logic [MB*BDW-1:0] e_rdata;

  logic [31:0] tx_dat [MB];
  logic [3:0]  tx_sel [MB];
  int          tx_wait [MB];
  logic [31:0] tx_rdat [MB];

  logic [31:0] adr_log [$];
  logic [31:0] dat_log [$];
  int cyc_cnt, err_cnt, rv_cnt;
  logic [MB*BDW-1:0] rep_last;
  logic [5:0] rep_len;

  logic [31:0] ra;
  logic [4:0] rl;
  int reb;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pkt_ready", pkt_ready_o, e_ready);
      chk("cyc", CYC_O, e_cyc);
      chk("stb", STB_O, e_cyc);
      chk("err", err_o, e_err);
      chk("reply_valid", reply_valid_o, e_rv);
      if (e_cyc) begin
        chk("we", WE_O, e_we);
        chk("adr", ADR_O, e_adr);
        chk("sel", SEL_O, e_sel);
        if (e_we) chk("dat", DAT_O, e_dat);
      end
      if (e_rv) begin
        chk("reply_len", reply_len_o, e_len);
        chk("reply_vnet", reply_vnet_o, e_vnet);
        chk("reply_data", reply_data_o, e_rdata);
      end
      if (CYC_O) begin
        adr_log.push_back(ADR_O);
        dat_log.push_back(DAT_O);
        cyc_cnt++;
      end
      if (err_o) err_cnt++;
      if (reply_valid_o) begin
        rv_cnt++;
        rep_last = reply_data_o;
        rep_len = reply_len_o;
      end
    end
  end

  // advance one cycle; idle expectations and noise on don't-care inputs
  task automatic step();
    @(posedge clk);
    #1;
    e_err = err_pend;
    err_pend = 1'b0;
    e_ready = 1'b1;
    e_cyc = 1'b0;
    e_we = 1'b0;
    e_rv = 1'b0;
    pkt_valid_i = 1'($urandom_range(0, 1));
    for (int i = 0; i < PKT_WIDTH; i++)
      pkt_i[i] = 1'($urandom_range(0, 1));
    vnet_id_i = 2'($urandom);
    ACK_I = 1'b0;
    ERR_I = 1'b0;
    reply_ready_i = 1'($urandom_range(0, 1));
    DAT_I = $urandom;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      pkt_valid_i = 1'b0;
      step();
    end
  endtask

  task automatic clr();
    adr_log.delete();
    dat_log.delete();
    cyc_cnt = 0;
    err_cnt = 0;
    rv_cnt = 0;
    rep_last = '0;
    rep_len = '0;
  endtask

  // called in an idle cycle; returns in the first cycle after the txn
  task automatic run_txn(input logic [31:0] a, input logic rd,
                         input logic [4:0] lf, input logic [1:0] vn,
                         input int err_b, input int to_b,
                         input int rst_b, input int rdy_dly);
    int lc;
    int w;
    logic [MB*BDW-1:0] cap;
    logic [FW-1:0] fl;
    lc = (int'(lf) > MB) ? MB : int'(lf);
    cap = '0;
    fl = '0;
    fl[HEAD_ADR_LSB +: 32] = a;
    fl[HEAD_CMD_BIT] = rd;
    fl[HEAD_LEN_LSB +: HEAD_LEN_W] = lf;
    fl[HEAD_VNET_LSB +: HEAD_VNET_W] = vn;
    pkt_i = '0;
    pkt_i[FW-1:0] = fl;
    for (int k = 0; k < MB; k++) begin
      fl = '0;
      fl[BODY_DAT_LSB +: 32] = tx_dat[k];
      fl[BODY_SEL_LSB +: 4] = tx_sel[k];
      pkt_i[(k+1)*FW +: FW] = fl;
    end
    vnet_id_i = vn;
    pkt_valid_i = 1'b1;
    step();
    e_ready = 1'b0;
    if (lc == 0) begin
      err_pend = 1'b1;
      step();
      return;
    end
    step();
    for (int k = 0; k < lc; k++) begin
      w = (k == to_b) ? TO + 10 : tx_wait[k];
      for (int c = 0; c <= w; c++) begin
        e_ready = 1'b0;
        e_cyc = 1'b1;
        e_we = !rd;
        e_adr = a + 32'(k) * 32'd4;
        e_dat = tx_dat[k];
        e_sel = rd ? 4'hF : tx_sel[k];
        if (k == rst_b && c == 0) begin
          rst = 1'b1;
          step();
          rst = 1'b0;
          return;
        end
        if (k == to_b && c == TO - 1) begin
          err_pend = 1'b1;
          step();
          return;
        end
        if (k == err_b && c == w) begin
          ERR_I = 1'b1;
          ACK_I = 1'($urandom_range(0, 1));
          err_pend = 1'b1;
          step();
          return;
        end
        if (c == w) begin
          ACK_I = 1'b1;
          DAT_I = tx_rdat[k];
          cap[k*BDW +: BDW] = tx_rdat[k];
        end
        step();
      end
    end
    if (!rd) return;
    for (int r = 0; r <= rdy_dly; r++) begin
      e_ready = 1'b0;
      e_rv = 1'b1;
      e_len = 6'(lc);
      e_vnet = vn;
      e_rdata = cap;
      reply_ready_i = (r == rdy_dly);
      step();
    end
  endtask

  task automatic fill(input int wmax);
    for (int k = 0; k < MB; k++) begin
      tx_dat[k] = $urandom;
      tx_sel[k] = 4'($urandom);
      tx_wait[k] = $urandom_range(0, wmax);
      tx_rdat[k] = $urandom;
    end
  endtask

  initial begin
    rst = 1'b1;
    pkt_valid_i = 1'b0;
    pkt_i = '0;
    vnet_id_i = '0;
    ACK_I = 1'b0;
    ERR_I = 1'b0;
    DAT_I = '0;
    reply_ready_i = 1'b0;
    step();
    cmp_en = 1'b1;
    e_ready = 1'b0;
    step();
    e_ready = 1'b0;
    step();
    rst = 1'b0;
    clr();
    idle_cycles(1);

    // single write beat
    fill(0);
    tx_dat[0] = 32'hDEADBEEF;
    tx_sel[0] = 4'hF;
    run_txn(32'h100, 1'b0, 5'd1, 2'd1, -1, -1, -1, 0);
    idle_cycles(1);
    chk("d1_beats", cyc_cnt, 1);
    chk("d1_adr", adr_log[0], 32'h100);
    chk("d1_dat", dat_log[0], 32'hDEADBEEF);
    chk("d1_reply", rv_cnt, 0);

    // four-beat write, one wait state per beat
    idle_cycles(1);
    clr();
    fill(0);
    for (int k = 0; k < MB; k++) tx_wait[k] = 1;
    run_txn(32'h1000, 1'b0, 5'd4, 2'd0, -1, -1, -1, 0);
    idle_cycles(1);
    chk("d2_cyc_cycles", cyc_cnt, 8);
    chk("d2_adr0", adr_log[0], 32'h1000);
    chk("d2_adr1", adr_log[2], 32'h1004);
    chk("d2_adr2", adr_log[4], 32'h1008);
    chk("d2_adr3", adr_log[6], 32'h100C);

    // three-beat read, reply held 4 cycles
    idle_cycles(1);
    clr();
    fill(2);
    tx_rdat[0] = 32'h11;
    tx_rdat[1] = 32'h22;
    tx_rdat[2] = 32'h33;
    run_txn(32'h200, 1'b1, 5'd3, 2'd2, -1, -1, -1, 3);
    idle_cycles(1);
    chk("d3_len", rep_len, 3);
    chk("d3_slice0", rep_last[31:0], 32'h11);
    chk("d3_slice1", rep_last[63:32], 32'h22);
    chk("d3_slice2", rep_last[95:64], 32'h33);
    chk("d3_slice3", rep_last[127:96], 32'h0);
    chk("d3_held", rv_cnt, 4);

    // ERR_I on beat 2 of 4
    idle_cycles(1);
    clr();
    fill(1);
    run_txn(32'h300, 1'b1, 5'd4, 2'd0, 1, -1, -1, 0);
    idle_cycles(1);
    chk("d4_err_pulses", err_cnt, 1);
    chk("d4_no_reply", rv_cnt, 0);

    // beat timeout
    idle_cycles(1);
    clr();
    fill(0);
    run_txn(32'h400, 1'b0, 5'd2, 2'd0, -1, 0, -1, 0);
    idle_cycles(1);
    chk("d5_to_cycles", cyc_cnt, TO);
    chk("d5_err_pulses", err_cnt, 1);

    // zero-length packet
    idle_cycles(1);
    clr();
    run_txn(32'h500, 1'b0, 5'd0, 2'd0, -1, -1, -1, 0);
    idle_cycles(1);
    chk("d6_no_bus", cyc_cnt, 0);
    chk("d6_err_pulses", err_cnt, 1);

    // length clamp plus address wrap
    idle_cycles(1);
    clr();
    fill(0);
    run_txn(32'hFFFF_FFF8, 1'b0, 5'd20, 2'd0, -1, -1, -1, 0);
    idle_cycles(1);
    chk("d7_beats", cyc_cnt, 8);
    chk("d7_wrap", adr_log[2], 32'h0);
    chk("d7_last", adr_log[7], 32'h14);

    // reset in mid read, then a normal write
    idle_cycles(1);
    clr();
    fill(0);
    run_txn(32'h600, 1'b1, 5'd5, 2'd3, -1, -1, 2, 0);
    fill(0);
    run_txn(32'h700, 1'b0, 5'd2, 2'd0, -1, -1, -1, 0);
    idle_cycles(1);
    chk("d8_no_reply", rv_cnt, 0);
    chk("d8_no_err", err_cnt, 0);
    chk("d8_cycles", cyc_cnt, 5);
    chk("d8_wr_adr", adr_log[4], 32'h704);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      fill(3);
      ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
      rl = ($urandom_range(0, 9) == 0) ? 5'($urandom)
                                       : 5'($urandom_range(1, 8));
      reb = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : -1;
      run_txn(ra, 1'($urandom_range(0, 1)), rl, 2'($urandom),
              reb, -1, -1, $urandom_range(0, 3));
      idle_cycles($urandom_range(0, 2));
    end

    idle_cycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
